// File: rtl/send_spi_process.sv
// SPI master (mode 0) that sends a header-tagged A/B frame pair on each start
// and returns the slave's reply words captured during those frames.
module send_spi_process #(
  parameter int CLK_DIV = 5,
  parameter int GAP     = 20
) (
  input  logic        clk_100,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] tx_data1,
  input  logic [15:0] tx_data2,
  output logic [15:0] rx_data1,
  output logic [15:0] rx_data2,
  output logic        busy,
  output logic        done,
  output logic        Send_SPICLK,
  output logic        Send_SPISIMO,
  input  logic        Send_SPISOMI,
  output logic        Send_SPISTE
);

  localparam logic [7:0]  DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP_A,
    GAP_B
  } state_t;

  state_t      state_reg, state_next;
  logic        frame_b_reg, frame_b_next;
  logic [7:0]  div_cnt_reg, div_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] tx_shift_reg, tx_shift_next;
  logic [15:0] word_b_reg, word_b_next;
  logic [15:0] rx_shift_reg, rx_shift_next;
  logic        sck_reg, sck_next;
  logic        mosi_reg, mosi_next;
  logic        ste_reg, ste_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [15:0] rx1_reg, rx1_next;
  logic [15:0] rx2_reg, rx2_next;

  logic [15:0] word_a;
  logic [15:0] word_b;
  logic        unused_hdr_bits;

  // The payload's top two bits are replaced by the frame header.
  assign word_a          = {2'b01, tx_data1[13:0]};
  assign word_b          = {2'b10, tx_data2[13:0]};
  assign unused_hdr_bits = ^{tx_data1[15:14], tx_data2[15:14]};

  always_ff @(posedge clk_100 or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      frame_b_reg  <= 1'b0;
      div_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      tx_shift_reg <= '0;
      word_b_reg   <= '0;
      rx_shift_reg <= '0;
      sck_reg      <= 1'b0;
      mosi_reg     <= 1'b0;
      ste_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rx1_reg      <= '0;
      rx2_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      frame_b_reg  <= frame_b_next;
      div_cnt_reg  <= div_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_shift_reg <= tx_shift_next;
      word_b_reg   <= word_b_next;
      rx_shift_reg <= rx_shift_next;
      sck_reg      <= sck_next;
      mosi_reg     <= mosi_next;
      ste_reg      <= ste_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      rx1_reg      <= rx1_next;
      rx2_reg      <= rx2_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    frame_b_next  = frame_b_reg;
    div_cnt_next  = div_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_shift_next = tx_shift_reg;
    word_b_next   = word_b_reg;
    rx_shift_next = rx_shift_reg;
    sck_next      = sck_reg;
    mosi_next     = mosi_reg;
    ste_next      = ste_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    rx1_next      = rx1_reg;
    rx2_next      = rx2_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = LEAD;
          frame_b_next  = 1'b0;
          tx_shift_next = word_a;
          word_b_next   = word_b;
          mosi_next     = word_a[15];
          ste_next      = 1'b0;
          busy_next     = 1'b1;
          div_cnt_next  = DIV_LOAD;
          bit_cnt_next  = '0;
          rx_shift_next = '0;
        end
      end

      // LEAD doubles as the low half of the first bit period.
      LEAD: begin
        if (div_cnt_reg == 8'd0) begin
          state_next    = SHIFT;
          sck_next      = 1'b1;
          rx_shift_next = {rx_shift_reg[14:0], Send_SPISOMI};
          div_cnt_next  = DIV_LOAD;
        end else begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end
      end

      SHIFT: begin
        if (div_cnt_reg == 8'd0) begin
          div_cnt_next = DIV_LOAD;
          if (sck_reg) begin
            sck_next = 1'b0;
            if (bit_cnt_reg == 5'd15) begin
              state_next = TRAIL;
            end else begin
              bit_cnt_next  = bit_cnt_reg + 5'd1;
              mosi_next     = tx_shift_reg[14];
              tx_shift_next = tx_shift_reg << 1;
            end
          end else begin
            sck_next      = 1'b1;
            rx_shift_next = {rx_shift_reg[14:0], Send_SPISOMI};
          end
        end else begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end
      end

      TRAIL: begin
        if (div_cnt_reg == 8'd0) begin
          ste_next     = 1'b1;
          gap_cnt_next = GAP_LOAD;
          if (frame_b_reg) begin
            rx2_next   = rx_shift_reg;
            done_next  = 1'b1;
            state_next = GAP_B;
          end else begin
            rx1_next   = rx_shift_reg;
            state_next = GAP_A;
          end
        end else begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end
      end

      GAP_A: begin
        if (gap_cnt_reg == 16'd0) begin
          state_next    = LEAD;
          frame_b_next  = 1'b1;
          tx_shift_next = word_b_reg;
          mosi_next     = word_b_reg[15];
          ste_next      = 1'b0;
          div_cnt_next  = DIV_LOAD;
          bit_cnt_next  = '0;
          rx_shift_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg - 16'd1;
        end
      end

      GAP_B: begin
        if (gap_cnt_reg == 16'd0) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          mosi_next  = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg - 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data1     = rx1_reg;
  assign rx_data2     = rx2_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign Send_SPICLK  = sck_reg;
  assign Send_SPISIMO = mosi_reg;
  assign Send_SPISTE  = ste_reg;

endmodule

// File: doc/send_spi_process.md
# send_spi_process

SPI master that drives the board-level receive-side SPI slave. On each `start` it sends two 16-bit frames back to back: frame A with header 2'b01 carrying channel-1 data, then frame B with header 2'b10 carrying channel-2 data. It captures the slave's reply word from each frame and presents both replies on parallel outputs. It sits on the sending board's `clk_100` domain and drives the SPI pins toward the remote SPI slave processor.

## Interface
- `CLK_DIV`, 5: SCK half-period in `clk_100` cycles. Legal range is 2..255. The default gives 10 MHz SCK.
- `GAP`, 20: number of `clk_100` cycles that SPISTE is held high between frames and after frame B. Legal range is 8..65535 (the minimum covers the slave's reply-load latency).

- `clk_100`  in  1  system clock, 100 MHz; the only clock.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to send one A/B frame pair. Honoured only in IDLE.
- `tx_data1`  in  16  channel-1 payload. Bits [13:0] are sent; bits [15:14] are ignored.
- `tx_data2`  in  16  channel-2 payload. Bits [13:0] are sent; bits [15:14] are ignored.
- `rx_data1`  out  16  reply word captured during frame A.
- `rx_data2`  out  16  reply word captured during frame B.
- `busy`  out  1  high from the first cycle after an accepted `start` until the state machine returns to IDLE.
- `done`  out  1  one-cycle pulse when both rx words have been updated.
- `Send_SPICLK`  out  1  SCK, mode 0 (idles low).
- `Send_SPISIMO`  out  1  MOSI, MSB first.
- `Send_SPISOMI`  in  1  MISO from the slave.
- `Send_SPISTE`  out  1  active-low slave enable.

## Operation
- **Framing and SPI mode**
  - Frame A word = {2'b01, tx_data1[13:0]}.
  - Frame B word = {2'b10, tx_data2[13:0]}.
  - Both words are latched in the cycle `start` is accepted. Later changes to `tx_data1`/`tx_data2` do not affect a pair in progress.
  - SPI mode 0: MISO is sampled on the SCK rising edge, and MOSI changes on the SCK falling edge.
  - 16 bits per frame, MSB first.
- **Reply routing**
  - The slave answers a 2'b10 frame by loading channel-1 data and a 2'b01 frame by loading channel-2 data, for transmission in the following frame.
  - The word received during frame A therefore goes to `rx_data1`, and the word received during frame B goes to `rx_data2`.
  - The first pair after reset carries whatever the slave had preloaded.
- **States**
  - IDLE: STE=1, SCK=0. `start` → LEAD_A.
  - LEAD: STE=0, MOSI=bit 15, held for CLK_DIV cycles → SHIFT.
  - SHIFT: 16 bit periods, each being SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
    - On each rising edge, shift MISO into the rx shift register.
    - On each falling edge except the last, present the next MOSI bit.
    - After the 16th falling edge → TRAIL.
  - TRAIL: SCK=0, STE=0, held for CLK_DIV cycles, then STE=1.
    - At the end of frame A, load `rx_data1` and → GAP_A.
    - At the end of frame B, load `rx_data2`, pulse `done`, and → GAP_B.
  - GAP_A: STE=1 for GAP cycles → LEAD_B.
  - GAP_B: STE=1 for GAP cycles → IDLE, with `busy` falling on entry to IDLE.
- **Boundary conditions**
  - `start` while busy is ignored: no queueing, and the latched tx words are unchanged.
  - `start` in the same cycle that GAP_B exits is ignored. It is accepted from the first IDLE cycle onward.
  - MOSI holds its last bit while STE is high and is 0 in IDLE.
  - `rx_data1`/`rx_data2` change only at the end-of-frame update and hold their value otherwise.
- **Reset (any time, including mid-frame)**
  - Outputs go immediately to: STE=1, SCK=0, MOSI=0, busy=0, done=0, rx_data1=0, rx_data2=0.
  - State goes to IDLE, and all counters and shift registers clear.
  - No partial frame is resumed after reset.

## Timing
- Cycle 0 is the cycle `start` is sampled.
- Cycle 1: STE falls, `busy` rises, MOSI = bit 15 of the frame A word.
- Within a frame, measured from the STE fall (cycle 0 of the frame):
  - The k-th SCK rise (k=1..16) is at cycle (2k-1)·CLK_DIV.
  - The k-th SCK fall is at cycle 2k·CLK_DIV.
  - STE rises at cycle 33·CLK_DIV.
  - STE is therefore low for exactly 33·CLK_DIV cycles per frame.
- The rx register update and `done` occur in the cycle STE rises.
- Full pair with `busy` high = 2·(33·CLK_DIV) + 2·GAP cycles. With the defaults, 370 cycles.
- Every output is registered and no output is combinational from an input.
- The counters are 8-bit (CLK_DIV), 16-bit (GAP) and 5-bit (bit index).

## Test plan
- **Basic pair, CLK_DIV=5, GAP=20:** `tx_data1`=0x1234, `tx_data2`=0xABCD, and the slave model returns 0x8001 then 0x4002.
  - MOSI frame A = 0x5234, frame B = 0xABCD.
  - `rx_data1`=0x8001, `rx_data2`=0x4002.
  - `done` is high for exactly 1 cycle, and `busy` is high for 370 cycles.
- **Timing check:** STE is low for 165 cycles per frame and high for 20 cycles between frames. There are 16 SCK rises per frame, the first at +5 cycles after the STE fall, and SCK is 0 whenever STE=1.
- **Header forcing:** `tx_data1`=0xFFFF and `tx_data2`=0x0000 give frame A = 0x7FFF and frame B = 0x8000.
- **Ignored start:**
  - `start` is pulsed at cycles 50 and 369 of a running pair. Exactly one pair is sent and the tx words are unchanged.
  - A `start` at the first IDLE cycle begins a new pair, with STE falling on the next cycle.
- **Loopback:** MISO tied to MOSI with 0x1234/0xABCD inputs gives `rx_data1`=0x5234 and `rx_data2`=0xABCD.
- **Mid-frame reset:** `RST` is asserted at SCK rise 8 of frame B.
  - In the same cycle: STE=1, SCK=0, busy=0, rx=0.
  - No `done` pulse occurs.
  - After release, a new `start` produces a clean full pair.
